sipo_word_rx: RTL and testbench

- Serial-to-parallel receiver directly downstream of the 4-bit PISO shift register.
- Consumes the PISO serial output `q` one qualified bit at a time and assembles WIDTH-bit words.
- Presents each completed word in a holding register with a valid/ready handshake to the parallel consumer.
- Flags overrun when a word completes while the previous one is still unaccepted.

---
 rtl/sipo_pkg.sv | 15 +
 rtl/sipo_shift_core.sv | 59 +++++
 rtl/sipo_word_rx.sv | 112 +++++++++++
 tb/tb_sipo_word_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel word receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sipo_pkg;

    // Receiver FSM encoding: SHIFT means a partial word is in progress.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sipo_state_t;

    // Word width shared with the upstream 4-bit PISO stage.
    localparam int SIPO_WIDTH_DEF = 4;

endpackage : sipo_pkg

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter; pulses done on the edge that samples the last bit of a word.
// Latency: done/word_nxt are combinational for the sampling edge; shreg/cnt update on that edge.
// Backpressure: none; every qualified bit is shifted in, clr wins over en.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr          : abort partial word (counter and shift register to 0)
//   en, sin      : qualified serial bit
//   word_nxt     : shift register contents including the current bit (valid when done=1)
//   cnt          : bits collected in the current partial word (registered)
//   done         : this edge completes a WIDTH-bit word
module sipo_shift_core #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] word_nxt,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic             w_done;

    // MSB-first matches the PISO shift order: first bit ends up in the top bit.
    always_comb begin
        w_shreg_nxt = r_shreg;
        if (MSB_FIRST) begin
            w_shreg_nxt = {r_shreg[WIDTH-2:0], sin};
        end else begin
            w_shreg_nxt = {sin, r_shreg[WIDTH-1:1]};
        end
    end

    // A clear in the same cycle discards the bit, so no completion can occur.
    assign w_done = en && !clr && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (en) begin
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_done ? '0 : r_cnt + 1'b1;
        end
    end

    assign word_nxt = w_shreg_nxt;
    assign cnt      = r_cnt;
    assign done     = w_done;

endmodule : sipo_shift_core

// File: rtl/sipo_word_rx.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a qualified bit stream into a holding register.
// Latency: dout/dout_valid update on the edge sampling the last bit (visible the next cycle).
// Backpressure: valid/ready on dout; a word completing while the holding register is full and not accepted is dropped and sets sticky overrun.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   sin, sin_valid        : serial input bit and its qualifier
//   sync_clr              : abort the partial word (holding register untouched)
//   dout, dout_valid      : holding register and its valid flag
//   dout_ready            : consumer accept
//   busy, bit_cnt         : partial word in progress / bits collected so far
//   overrun, ovr_clr      : sticky drop flag and its clear
module sipo_word_rx
    import sipo_pkg::*;
#(
    parameter int   WIDTH     = SIPO_WIDTH_DEF,
    parameter bit   MSB_FIRST = 1'b1,
    localparam int  CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sync_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
    input  logic             ovr_clr
);

    sipo_state_t      r_state;
    sipo_state_t      w_state_nxt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;
    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_accept;
    logic             w_load;
    logic             w_drop;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (sync_clr),
        .en       (sin_valid),
        .sin      (sin),
        .word_nxt (w_word),
        .cnt      (bit_cnt),
        .done     (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (sync_clr) begin
            w_state_nxt = ST_IDLE;
        end else if (sin_valid) begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_SHIFT;
                ST_SHIFT: w_state_nxt = w_done ? ST_IDLE : ST_SHIFT;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // An accept in the same cycle frees the holding register for the new word.
    assign w_accept = r_dout_valid && dout_ready;
    assign w_load   = w_done && (!r_dout_valid || dout_ready);
    assign w_drop   = w_done && r_dout_valid && !dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_load) begin
                r_dout       <= w_word;
                r_dout_valid <= 1'b1;
            end else if (w_accept) begin
                r_dout_valid <= 1'b0;
            end
            // Setting beats a simultaneous clear so no drop goes unreported.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_state == ST_SHIFT);

endmodule : sipo_word_rx

// File: tb/tb_sipo_word_rx.sv
module tb_sipo_word_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sync_clr = 1'b0;
    logic       dout_ready = 1'b0;
    logic       ovr_clr = 1'b0;

    logic [3:0] dout_m, dout_l;
    logic       dv_m, dv_l, busy_m, busy_l, ovr_m, ovr_l;
    logic [2:0] cnt_m, cnt_l;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sipo_word_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sync_clr   (sync_clr),
        .dout       (dout_m),
        .dout_valid (dv_m),
        .dout_ready (dout_ready),
        .busy       (busy_m),
        .bit_cnt    (cnt_m),
        .overrun    (ovr_m),
        .ovr_clr    (ovr_clr)
    );

    sipo_word_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sync_clr   (sync_clr),
        .dout       (dout_l),
        .dout_valid (dv_l),
        .dout_ready (dout_ready),
        .busy       (busy_l),
        .bit_cnt    (cnt_l),
        .overrun    (ovr_l),
        .ovr_clr    (ovr_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin       = b;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    // Sends w[3] first; rdy_last drives dout_ready only on the final bit's cycle.
    task automatic send_word(input logic [3:0] w, input logic rdy_last);
        for (int i = 3; i >= 0; i--) begin
            sin        = w[i];
            sin_valid  = 1'b1;
            dout_ready = (i == 0) ? rdy_last : 1'b0;
            tick();
        end
        sin_valid  = 1'b0;
        dout_ready = 1'b0;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_dout", dout_m, 4'h0);
        chk("rst_dv", dv_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_cnt", cnt_m, 3'd0);
        chk("rst_ovr", ovr_m, 1'b0);

        // Basic word 1,0,1,1 with dout_ready low
        send_bit(1'b1);
        send_bit(1'b0);
        chk("mid_cnt", cnt_m, 3'd2);
        chk("mid_busy", busy_m, 1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("w1_dout", dout_m, 4'b1011);
        chk("w1_dv", dv_m, 1'b1);
        chk("w1_busy", busy_m, 1'b0);
        chk("w1_cnt", cnt_m, 3'd0);
        chk("lsb_dout", dout_l, 4'b1101);
        chk("lsb_dv", dv_l, 1'b1);
        gap(3);
        chk("w1_hold_dout", dout_m, 4'b1011);
        chk("w1_hold_dv", dv_m, 1'b1);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("w1_acc_dv", dv_m, 1'b0);
        chk("w1_acc_ovr", ovr_m, 1'b0);

        // Gapped bits, then sync_clr beats a simultaneous bit
        send_bit(1'b1);
        gap(3);
        send_bit(1'b1);
        gap(3);
        chk("gap_cnt", cnt_m, 3'd2);
        sync_clr  = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b1;
        tick();
        sync_clr  = 1'b0;
        sin_valid = 1'b0;
        chk("clr_cnt", cnt_m, 3'd0);
        chk("clr_busy", busy_m, 1'b0);
        chk("clr_dv", dv_m, 1'b0);
        send_word(4'b0110, 1'b0);
        chk("w2_dout", dout_m, 4'b0110);
        chk("w2_dv", dv_m, 1'b1);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("w2_acc_dv", dv_m, 1'b0);

        // Overrun: A held, B dropped
        send_word(4'b1011, 1'b0);
        chk("A_dout", dout_m, 4'b1011);
        send_word(4'b0101, 1'b0);
        chk("ovr_set", ovr_m, 1'b1);
        chk("ovr_dout", dout_m, 4'b1011);
        chk("ovr_dv", dv_m, 1'b1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr", ovr_m, 1'b0);
        // Same-edge accept and load
        send_word(4'b0101, 1'b1);
        chk("B_dout", dout_m, 4'b0101);
        chk("B_dv", dv_m, 1'b1);
        chk("B_ovr", ovr_m, 1'b0);
        // Set wins over simultaneous clear
        ovr_clr = 1'b1;
        send_word(4'b1110, 1'b0);
        ovr_clr = 1'b0;
        chk("ovr_set_wins", ovr_m, 1'b1);
        chk("ovr_keep_dout", dout_m, 4'b0101);

        // Reset mid-word while holding a word
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_dout", dout_m, 4'h0);
        chk("rst2_dv", dv_m, 1'b0);
        chk("rst2_busy", busy_m, 1'b0);
        chk("rst2_cnt", cnt_m, 3'd0);
        chk("rst2_ovr", ovr_m, 1'b0);
        send_word(4'b1001, 1'b0);
        chk("w3_dout", dout_m, 4'b1001);
        chk("w3_dv", dv_m, 1'b1);
        dout_ready = 1'b1;
        tick();
        chk("w3_acc_dv", dv_m, 1'b0);

        // Back-to-back words with dout_ready tied high
        for (int i = 0; i < 8; i++) begin
            sin       = (i < 4);
            sin_valid = 1'b1;
            tick();
            if (i == 3) begin
                chk("b2b_w0_dout", dout_m, 4'b1111);
                chk("b2b_w0_dv", dv_m, 1'b1);
            end
            if (i == 4) chk("b2b_gap_dv", dv_m, 1'b0);
        end
        sin_valid = 1'b0;
        chk("b2b_w1_dout", dout_m, 4'b0000);
        chk("b2b_w1_dv", dv_m, 1'b1);
        chk("b2b_ovr", ovr_m, 1'b0);
        tick();
        chk("b2b_end_dv", dv_m, 1'b0);
        dout_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sipo_word_rx
